// File: rtl/cfo_nco.sv
// cfo_nco: numerically controlled oscillator for carrier-frequency-offset
// de-rotation. It holds the latest frequency word from the CFO loop filter
// and advances a phase accumulator once per receive sample. The phase is
// mapped to cos/sin through a three-stage pipelined quarter-wave ROM.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   freq_valid_i   loads freq_word_i into the frequency register
//   freq_word_i    signed phase increment per sample (two's complement)
//   freq_clear_i   synchronous clear of frequency and phase (re-acquire)
//   sample_valid_i one strobe per receive sample
//   phase_o        phase tag of the current output sample
//   cos_o, sin_o   signed de-rotation phasor
//   nco_valid_o    qualifies phase_o/cos_o/sin_o, 3 cycles after the strobe
module cfo_nco #(
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 10,
    parameter int AMP_WIDTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           freq_valid_i,
    input  logic [PHASE_WIDTH-1:0]         freq_word_i,
    input  logic                           freq_clear_i,
    input  logic                           sample_valid_i,
    output logic [PHASE_WIDTH-1:0]         phase_o,
    output logic signed [AMP_WIDTH-1:0]    cos_o,
    output logic signed [AMP_WIDTH-1:0]    sin_o,
    output logic                           nco_valid_o
);

    localparam int  IDX_W  = LUT_ADDR_WIDTH - 2;
    localparam int  QN     = 1 << IDX_W;
    localparam int  AMP    = (1 << (AMP_WIDTH - 1)) - 1;
    localparam real TWO_PI = 6.283185307179586;

    // Quarter-wave entry T[k] = round(A*sin(2*pi*(k+0.5)/N)). Evaluated only
    // at elaboration; the Taylor series is accurate far below one LSB over
    // the first quadrant, and every entry is positive so +0.5 rounds.
    function automatic int rom_entry(input int k);
        real x;
        real term;
        real acc;
        x    = TWO_PI * (real'(k) + 0.5) / real'(QN * 4);
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return $rtoi(real'(AMP) * acc + 0.5);
    endfunction

    logic signed [AMP_WIDTH-1:0] rom_s [QN];

    for (genvar k = 0; k < QN; k++) begin : g_rom
        localparam int ENTRY = rom_entry(k);
        assign rom_s[k] = AMP_WIDTH'(ENTRY);
    end

    logic [PHASE_WIDTH-1:0]      freq_r;
    logic [PHASE_WIDTH-1:0]      phase_acc_r;

    logic                        s1_valid_r;
    logic [PHASE_WIDTH-1:0]      s1_phase_r;
    logic [1:0]                  s1_q_r;
    logic [IDX_W-1:0]            s1_j_r;
    logic [IDX_W-1:0]            s1_jm_r;

    logic                        s2_valid_r;
    logic [PHASE_WIDTH-1:0]      s2_phase_r;
    logic [1:0]                  s2_q_r;
    logic signed [AMP_WIDTH-1:0] s2_tj_r;
    logic signed [AMP_WIDTH-1:0] s2_tjm_r;

    logic signed [AMP_WIDTH-1:0] cos_s;
    logic signed [AMP_WIDTH-1:0] sin_s;

    // Frequency register and phase accumulator. Clear wins over a new word
    // and over the increment; the increment always uses the word held before
    // this edge, so a simultaneous load takes effect on the next sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_r      <= '0;
            phase_acc_r <= '0;
        end else if (freq_clear_i) begin
            freq_r      <= '0;
            phase_acc_r <= '0;
        end else begin
            if (freq_valid_i) begin
                freq_r <= freq_word_i;
            end
            if (sample_valid_i) begin
                phase_acc_r <= phase_acc_r + freq_r;
            end
        end
    end

    // Stage 1: tag the sample with the pre-increment (and pre-clear) phase
    // and split its top bits into quadrant and mirrored table indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_phase_r <= '0;
            s1_q_r     <= 2'd0;
            s1_j_r     <= '0;
            s1_jm_r    <= '0;
        end else begin
            s1_valid_r <= sample_valid_i;
            if (sample_valid_i) begin
                s1_phase_r <= phase_acc_r;
                s1_q_r     <= phase_acc_r[PHASE_WIDTH-1 -: 2];
                s1_j_r     <= phase_acc_r[PHASE_WIDTH-3 -: IDX_W];
                s1_jm_r    <= ~phase_acc_r[PHASE_WIDTH-3 -: IDX_W];
            end
        end
    end

    // Stage 2: read both table entries; jm addresses the mirrored quarter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_phase_r <= '0;
            s2_q_r     <= 2'd0;
            s2_tj_r    <= '0;
            s2_tjm_r   <= '0;
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_phase_r <= s1_phase_r;
                s2_q_r     <= s1_q_r;
                s2_tj_r    <= rom_s[s1_j_r];
                s2_tjm_r   <= rom_s[s1_jm_r];
            end
        end
    end

    // Stage 3 combinational part: quadrant sign and select. Entries never
    // reach -2^(AMP_WIDTH-1), so the negations cannot overflow.
    always_comb begin
        cos_s = s2_tjm_r;
        sin_s = s2_tj_r;
        case (s2_q_r)
            2'd0: begin
                sin_s = s2_tj_r;
                cos_s = s2_tjm_r;
            end
            2'd1: begin
                sin_s = s2_tjm_r;
                cos_s = -s2_tj_r;
            end
            2'd2: begin
                sin_s = -s2_tj_r;
                cos_s = -s2_tjm_r;
            end
            2'd3: begin
                sin_s = -s2_tjm_r;
                cos_s = s2_tj_r;
            end
            default: begin
                sin_s = s2_tj_r;
                cos_s = s2_tjm_r;
            end
        endcase
    end

    // Stage 3 output registers; data holds while no sample is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nco_valid_o <= 1'b0;
            phase_o     <= '0;
            cos_o       <= '0;
            sin_o       <= '0;
        end else begin
            nco_valid_o <= s2_valid_r;
            if (s2_valid_r) begin
                phase_o <= s2_phase_r;
                cos_o   <= cos_s;
                sin_o   <= sin_s;
            end
        end
    end

endmodule

// File: doc/cfo_nco.md
Name: cfo_nco

Overview:
Numerically controlled oscillator that consumes the CFO loop filter's frequency word and produces the de-rotation phasor for the receive path. The block sits directly downstream of the CFO PI loop filter. It holds the latest frequency word, advances a phase accumulator once per sample strobe, and maps the phase to cos/sin through a pipelined quarter-wave LUT. The mixer consumes cos_o/sin_o.

Parameters:
PHASE_WIDTH, 32, width of frequency word and phase accumulator (full circle = 2^PHASE_WIDTH)
LUT_ADDR_WIDTH, 10, phase bits used for lookup (N = 2^LUT_ADDR_WIDTH points per circle, quarter table of N/4 entries); >= 4
AMP_WIDTH, 16, signed output width; amplitude A = 2^(AMP_WIDTH-1)-1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
freq_valid_i  input  1  strobe from loop filter, freq_word_i valid
freq_word_i  input  PHASE_WIDTH  signed phase increment per sample
freq_clear_i  input  1  synchronous clear of frequency and phase (re-acquire)
sample_valid_i  input  1  one strobe per receive sample
phase_o  output  PHASE_WIDTH  phase used for the current output sample
cos_o  output  AMP_WIDTH  signed cosine
sin_o  output  AMP_WIDTH  signed sine
nco_valid_o  output  1  qualifies phase_o/cos_o/sin_o

Behaviour:
- Reset (rst_n low, async): freq_reg=0, phase_acc=0, all pipeline valids 0, phase_o=0, cos_o=0, sin_o=0, nco_valid_o=0. A reset mid-pipeline discards in-flight samples; no nco_valid_o pulses follow from pre-reset strobes.
- freq_reg loads freq_word_i on a clk edge with freq_valid_i=1. The value holds between strobes.
- Stage 0, sample_valid_i=1: the sample is tagged with the current phase_acc (pre-increment). Then phase_acc <= phase_acc + freq_reg, modulo 2^PHASE_WIDTH. Wrap is silent; the signed increment is added as two's complement.
- Simultaneous freq_valid_i and sample_valid_i: the increment uses the OLD freq_reg. The new word takes effect on the next sample.
- freq_clear_i=1: freq_reg<=0, phase_acc<=0. It has priority over freq_valid_i and over the increment. A sample strobed in the same cycle is still emitted, using the pre-clear phase_acc. Samples already in the pipeline complete normally.
- No sample_valid_i: phase_acc holds and no valid is generated.
- Lookup pipeline: 3 registered stages. nco_valid_o and the outputs appear exactly 3 cycles after sample_valid_i. The pipeline is fully pipelined and accepts a strobe every cycle. phase_o is the tagged phase delayed to align with cos_o/sin_o.
  - Stage 1: take the top LUT_ADDR_WIDTH bits of the tagged phase. q = top 2 bits; j = next LUT_ADDR_WIDTH-2 bits; jm = bitwise NOT of j.
  - Stage 2: ROM read of T[j] and T[jm].
  - Stage 3: sign and select, then register the outputs.
- ROM contents: T[k] = round(A*sin(2*pi*(k+0.5)/N)), for k = 0..N/4-1. The half-entry offset keeps entries nonzero and ≤ A, so negation never overflows.
- Quadrant mapping:
  - q0: sin=T[j], cos=T[jm]
  - q1: sin=T[jm], cos=-T[j]
  - q2: sin=-T[j], cos=-T[jm]
  - q3: sin=-T[jm], cos=T[j]
- Outputs hold their last value when nco_valid_o=0.
- The ROM is synthesizable: initialized at elaboration from the formula, with no runtime real math.

Test Plan:
- Reset: drive strobes, then assert rst_n low asynchronously mid-pipeline -> outputs immediately 0, nco_valid_o=0, no valid pulses for 3 cycles after release.
- Defaults, freq 0, 5 strobes -> phase_o=0 each time; sin_o=101, cos_o=32767; nco_valid_o exactly 3 cycles after each strobe.
- Quarter-cycle step: freq_word 0x40000000, 4 back-to-back strobes -> phase_o 0, 0x40000000, 0x80000000, 0xC0000000; sin 101, 32767, -101, -32767; cos 32767, -101, -32767, 101.
- Negative frequency and wrap: freq_word -0x40000000 -> phase_o 0, 0xC0000000, 0x80000000, 0x40000000, 0 (wraps silently).
- Simultaneous update: with freq 0x40000000, assert freq_valid_i=0x20000000 in the same cycle as a strobe -> next tagged phases advance by 0x40000000 once, then by 0x20000000.
- Clear: after 3 strobes at 0x40000000, pulse freq_clear_i with a strobe -> that sample is tagged 0xC0000000; subsequent samples are tagged 0 until a new freq_valid_i.
